// File: rtl/debug_reg_dump_engine_pkg.sv
// Shared types and default sizing for the debug register dump engine.
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HALT    = 3'd1,
        READ    = 3'd2,
        SEND    = 3'd3,
        CKSUM   = 3'd4,
        RELEASE = 3'd5
    } dump_state_e;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_REG_NUM      = 32;
    localparam int DEF_HALT_TIMEOUT = 1024;
    // Register address width and stream index width (one extra code for the checksum beat).
    localparam int DEF_ADDR_W       = $clog2(DEF_REG_NUM);
    localparam int DEF_INDEX_W      = $clog2(DEF_REG_NUM + 1);

endpackage

// File: rtl/debug_reg_dump_engine_halt_timeout_timer.sv
// Halt-acknowledge wait counter: cleared while idle, counts while waiting, flags the last allowed cycle.
module halt_timeout_timer #(
    parameter int HALT_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int TW = $clog2(HALT_TIMEOUT + 1);

    logic [TW-1:0] r_count;

    // Wait-cycle counter with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == TW'(HALT_TIMEOUT - 1));

endmodule

// File: rtl/debug_reg_dump_engine.sv
// Halts the core, sweeps the register file debug port and streams every word over valid/ready.
// Optional trailing XOR checksum beat when DEBUG_DUMP_CHECKSUM_EN is defined.
module debug_reg_dump_engine
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int REG_NUM      = DEF_REG_NUM,
    parameter int HALT_TIMEOUT = DEF_HALT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         dump_req,
    output logic                         dump_busy,
    output logic                         dump_done,
    output logic                         dump_err,
    output logic                         halt_req,
    input  logic                         halt_ack,
    output logic                         debug_mode,
    output logic [$clog2(REG_NUM)-1:0]   debug_reg_addr,
    input  logic [DATA_WIDTH-1:0]        debug_reg_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [$clog2(REG_NUM+1)-1:0] m_index,
    output logic                         m_last
);

    localparam int AW = $clog2(REG_NUM);
    localparam int IW = $clog2(REG_NUM + 1);

    dump_state_e     r_state;
    logic [AW-1:0]   r_index;
    logic            r_dump_busy;
    logic            r_dump_done;
    logic            r_dump_err;
    logic            r_halt_req;
    logic            r_debug_mode;
    logic            r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [IW-1:0]   r_m_index;
    logic            r_m_last;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;
`endif
    logic            w_timer_clear;
    logic            w_timer_enable;
    logic            w_timer_expired;

    assign w_timer_clear  = (r_state == IDLE);
    assign w_timer_enable = (r_state == HALT) && !halt_ack;

    halt_timeout_timer #(
        .HALT_TIMEOUT (HALT_TIMEOUT)
    ) u_halt_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_enable),
        .o_expired (w_timer_expired)
    );

    // Dump sequencer: halt handshake, read/send sweep, optional checksum beat, release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_dump_busy  <= 1'b0;
            r_dump_done  <= 1'b0;
            r_dump_err   <= 1'b0;
            r_halt_req   <= 1'b0;
            r_debug_mode <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_index    <= '0;
            r_m_last     <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            r_checksum   <= '0;
`endif
        end else begin
            r_dump_done <= 1'b0;
            r_dump_err  <= 1'b0;
            case (r_state)
                IDLE: begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    r_checksum <= '0;
`endif
                    if (dump_req) begin
                        r_state     <= HALT;
                        r_halt_req  <= 1'b1;
                        r_dump_busy <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                HALT: begin
                    if (halt_ack) begin
                        r_state      <= READ;
                        r_debug_mode <= 1'b1;
                        r_index      <= '0;
                    end else if (w_timer_expired) begin
                        r_state     <= IDLE;
                        r_dump_err  <= 1'b1;
                        r_halt_req  <= 1'b0;
                        r_dump_busy <= 1'b0;
                    end else begin
                        r_state <= HALT;
                    end
                end
                READ: begin
                    if (!halt_ack) begin
                        r_state      <= IDLE;
                        r_dump_err   <= 1'b1;
                        r_halt_req   <= 1'b0;
                        r_debug_mode <= 1'b0;
                        r_dump_busy  <= 1'b0;
                    end else begin
                        r_state   <= SEND;
                        r_m_valid <= 1'b1;
                        r_m_data  <= debug_reg_data;
                        r_m_index <= IW'(r_index);
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        r_m_last   <= 1'b0;
                        r_checksum <= r_checksum ^ debug_reg_data;
`else
                        r_m_last   <= (r_index == AW'(REG_NUM - 1));
`endif
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        if (r_index < AW'(REG_NUM - 1)) begin
                            r_index <= r_index + AW'(1);
                            r_state <= READ;
                        end else begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                            // Checksum beat follows the last register beat back-to-back.
                            r_state   <= CKSUM;
                            r_m_valid <= 1'b1;
                            r_m_data  <= r_checksum;
                            r_m_index <= IW'(REG_NUM);
                            r_m_last  <= 1'b1;
`else
                            r_state   <= RELEASE;
`endif
                        end
                    end else begin
                        r_state <= SEND;
                    end
                end
`ifdef DEBUG_DUMP_CHECKSUM_EN
                CKSUM: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_state   <= RELEASE;
                    end else begin
                        r_state <= CKSUM;
                    end
                end
`endif
                RELEASE: begin
                    r_halt_req   <= 1'b0;
                    r_debug_mode <= 1'b0;
                    r_dump_busy  <= 1'b0;
                    r_dump_done  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dump_busy      = r_dump_busy;
    assign dump_done      = r_dump_done;
    assign dump_err       = r_dump_err;
    assign halt_req       = r_halt_req;
    assign debug_mode     = r_debug_mode;
    assign debug_reg_addr = r_index;
    assign m_valid        = r_m_valid;
    assign m_data         = r_m_data;
    assign m_index        = r_m_index;
    assign m_last         = r_m_last;

endmodule

// File: tb/tb_debug_reg_dump_engine.sv
// Directed bench for debug_reg_dump_engine: register file model, delayed halt responder, stream monitor.
module tb_debug_reg_dump_engine;

    localparam int DW = 32;
    localparam int RN = 32;
    localparam int HT = 16;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int NBEATS = RN + 1;
`else
    localparam int NBEATS = RN;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dump_req;
    logic          dump_busy, dump_done, dump_err;
    logic          halt_req, halt_ack, debug_mode;
    logic [4:0]    debug_reg_addr;
    logic [DW-1:0] debug_reg_data;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;
    logic [5:0]    m_index;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] regs [RN];
    logic [2:0]    hr_d = 3'd0;
    logic [1:0]    rdy_phase = 2'd0;
    logic          ack_en, drop_mode, rdy_throttle, mon_clr;

    logic [DW-1:0] q_data [$];
    logic [5:0]    q_index [$];
    logic          q_last [$];
    int            beats_seen, done_cnt, err_cnt, last_cnt, stall_bad;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [5:0]    prev_index;

    always #5 clk = ~clk;

    debug_reg_dump_engine #(
        .DATA_WIDTH   (DW),
        .REG_NUM      (RN),
        .HALT_TIMEOUT (HT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dump_req       (dump_req),
        .dump_busy      (dump_busy),
        .dump_done      (dump_done),
        .dump_err       (dump_err),
        .halt_req       (halt_req),
        .halt_ack       (halt_ack),
        .debug_mode     (debug_mode),
        .debug_reg_addr (debug_reg_addr),
        .debug_reg_data (debug_reg_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_index        (m_index),
        .m_last         (m_last)
    );

    assign debug_reg_data = regs[debug_reg_addr];
    // Core acknowledges three cycles after halt_req; drop mode withdraws it once six beats are out.
    assign halt_ack = ack_en && hr_d[2] && !(drop_mode && (beats_seen >= 6));
    assign m_ready  = rdy_throttle ? (rdy_phase == 2'd0) : 1'b1;

    always @(posedge clk) begin
        hr_d      <= {hr_d[1:0], halt_req};
        rdy_phase <= (rdy_phase == 2'd2) ? 2'd0 : rdy_phase + 2'd1;
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            q_data.delete();
            q_index.delete();
            q_last.delete();
            beats_seen <= 0;
            done_cnt   <= 0;
            err_cnt    <= 0;
            last_cnt   <= 0;
            stall_bad  <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                q_data.push_back(m_data);
                q_index.push_back(m_index);
                q_last.push_back(m_last);
                beats_seen <= beats_seen + 1;
                if (m_last) last_cnt <= last_cnt + 1;
            end
            if (prev_stall && (!m_valid || m_data != prev_data || m_index != prev_index))
                stall_bad <= stall_bad + 1;
            if (dump_done) done_cnt <= done_cnt + 1;
            if (dump_err)  err_cnt  <= err_cnt + 1;
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_index <= m_index;
        end
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic start_dump();
        @(posedge clk);
        #1 dump_req = 1'b1;
        @(posedge clk);
        #1 dump_req = 1'b0;
    endtask

    task automatic wait_end(input int bound, output int n);
        n = 0;
        while (n < bound && !(dump_done || dump_err)) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_value({tag, "_busy"}, dump_busy, 0);
        check_value({tag, "_done"}, dump_done, 0);
        check_value({tag, "_err"}, dump_err, 0);
        check_value({tag, "_halt"}, halt_req, 0);
        check_value({tag, "_dbg"}, debug_mode, 0);
        check_value({tag, "_addr"}, debug_reg_addr, 0);
        check_value({tag, "_valid"}, m_valid, 0);
        check_value({tag, "_data"}, m_data, 0);
        check_value({tag, "_index"}, m_index, 0);
        check_value({tag, "_last"}, m_last, 0);
    endtask

    task automatic verify_stream(input string tag, input int exp_beats);
        logic [DW-1:0] ck;
        logic [DW-1:0] ev;
        int n;
        ck = '0;
        for (int i = 0; i < RN; i++) ck = ck ^ regs[i];
        check_value({tag, "_beats"}, q_data.size(), exp_beats);
        n = (q_data.size() < exp_beats) ? q_data.size() : exp_beats;
        for (int i = 0; i < n; i++) begin
            ev = (i < RN) ? regs[i] : ck;
            check_value($sformatf("%s_index%0d", tag, i), q_index[i], i);
            check_value($sformatf("%s_data%0d", tag, i), q_data[i], ev);
            check_value($sformatf("%s_last%0d", tag, i), q_last[i], (i == NBEATS - 1) ? 1 : 0);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; dump_req = 1'b0; ack_en = 1'b1; drop_mode = 1'b0;
        rdy_throttle = 1'b0; mon_clr = 1'b1;
        for (int i = 0; i < RN; i++) regs[i] = (i == 0) ? 32'h0 : 32'h1000 + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        clear_mon();

        // 1: plain dump, halt ack after three cycles, ready always high
        start_dump();
        check_value("t1_busy_on_accept", dump_busy, 1);
        wait_end(400, n);
        check_value("t1_no_timeout", (n < 400), 1);
        check_value("t1_done_pulse", dump_done, 1);
        @(posedge clk);
        #1;
        check_value("t1_done_once", done_cnt, 1);
        check_value("t1_err_none", err_cnt, 0);
        check_value("t1_last_count", last_cnt, 1);
        check_value("t1_halt_released", halt_req, 0);
        check_value("t1_dbg_released", debug_mode, 0);
        check_value("t1_busy_released", dump_busy, 0);
        check_value("t1_data1_hand", (q_data.size() > 1) ? q_data[1] : 32'hDEAD, 32'h1001);
        check_value("t1_data31_hand", (q_data.size() > 31) ? q_data[31] : 32'hDEAD, 32'h101F);
        verify_stream("t1", NBEATS);

        // 2: halt never acknowledged -> timeout
        ack_en = 1'b0;
        clear_mon();
        start_dump();
        wait_end(100, n);
        check_value("t2_err_latency", n, HT);
        check_value("t2_err_pulse", dump_err, 1);
        check_value("t2_halt_low", halt_req, 0);
        check_value("t2_busy_low", dump_busy, 0);
        @(posedge clk);
        #1;
        check_value("t2_err_single", dump_err, 0);
        check_value("t2_no_beats", q_data.size(), 0);
        ack_en = 1'b1;

        // 3: downstream accepts one cycle in three
        rdy_throttle = 1'b1;
        repeat (4) @(posedge clk);
        clear_mon();
        start_dump();
        wait_end(600, n);
        check_value("t3_done", dump_done, 1);
        @(posedge clk);
        #1;
        check_value("t3_stall_stable", stall_bad, 0);
        verify_stream("t3", NBEATS);
        rdy_throttle = 1'b0;

        // 4: halt lost after beat 5
        repeat (4) @(posedge clk);
        drop_mode = 1'b1;
        clear_mon();
        start_dump();
        wait_end(400, n);
        check_value("t4_err", dump_err, 1);
        check_value("t4_dbg_low", debug_mode, 0);
        check_value("t4_halt_low", halt_req, 0);
        @(posedge clk);
        #1;
        check_value("t4_no_done", done_cnt, 0);
        check_value("t4_no_last", last_cnt, 0);
        verify_stream("t4", 6);
        drop_mode = 1'b0;

        // 5: reset during beat 10, dump_req repeated while busy
        repeat (6) @(posedge clk);
        clear_mon();
        start_dump();
        n = 0;
        while (n < 300 && !(m_valid && m_index == 6'd10)) begin
            @(posedge clk);
            #1;
            n++;
            dump_req = (n == 8);
        end
        dump_req = 1'b0;
        check_value("t5_reached_beat10", (n < 300), 1);
        check_value("t5_busy_before_reset", dump_busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("t5_reset");
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        check_value("t5_idle_after_reset", dump_busy, 0);
        clear_mon();
        start_dump();
        n = 0;
        while (n < 400 && !(dump_done || dump_err)) begin
            @(posedge clk);
            #1;
            n++;
            dump_req = (n == 20);
        end
        dump_req = 1'b0;
        check_value("t5_fresh_done", dump_done, 1);
        repeat (10) @(posedge clk);
        #1;
        check_value("t5_extra_req_ignored", dump_busy, 0);
        check_value("t5_fresh_done_once", done_cnt, 1);
        verify_stream("t5", NBEATS);

        // 6: xi = i, then x31 = 0xFFFF
        for (int i = 0; i < RN; i++) regs[i] = 32'(i);
        clear_mon();
        start_dump();
        wait_end(400, n);
        @(posedge clk);
        #1;
        verify_stream("t6a", NBEATS);
`ifdef DEBUG_DUMP_CHECKSUM_EN
        check_value("t6a_cksum_hand", (q_data.size() > 32) ? q_data[32] : 32'hDEAD, 32'h0);
`endif
        regs[31] = 32'hFFFF;
        clear_mon();
        start_dump();
        wait_end(400, n);
        @(posedge clk);
        #1;
        verify_stream("t6b", NBEATS);
`ifdef DEBUG_DUMP_CHECKSUM_EN
        check_value("t6b_cksum_hand", (q_data.size() > 32) ? q_data[32] : 32'hDEAD, 32'hFFE0);
`else
        check_value("t6b_x31_hand", (q_data.size() > 31) ? q_data[31] : 32'hDEAD, 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
